neuron_result_reader: RTL and testbench
=======================================

# neuron_result_reader

Output-side reader for the neural accelerator. Once a forward pass completes, it walks the output-layer region of the neuron dual-port RAM through that RAM's read port and streams each activation out over a valid/ready interface. While streaming, it tracks the signed maximum activation and its index, so the host receives a classification result with no extra pass.

## Interface
- `ADDR_W`, 8: neuron RAM address width.
- `DATA_W`, 8: activation width; activations are two's-complement signed.
- `BASE_ADDR`, 8'd0: RAM address of output neuron 0.
- `NUM_OUT`, 10: number of output neurons; legal range 1..2^ADDR_W.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin readout; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last element handshakes.
- `rd_en` out 1: RAM read strobe.
- `rd_addr` out ADDR_W: RAM read address.
- `rd_data` in DATA_W: RAM read data, valid the cycle after `rd_en`.
- `m_data` out DATA_W: streamed activation.
- `m_index` out ADDR_W: neuron index of `m_data`, from 0 to NUM_OUT-1.
- `m_last` out 1: high with the final element.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `argmax_index` out ADDR_W: index of the largest activation.
- `argmax_value` out DATA_W: value of the largest activation.
- `argmax_valid` out 1: argmax outputs are final.

## Operation
- FSM states: IDLE, READ, CAPT, SEND, DONE.
- IDLE + `start`:
  - clear the index counter to 0 and clear the argmax tracker;
  - drop `argmax_valid`;
  - go to READ.
- READ: `rd_en`=1 and `rd_addr` = (BASE_ADDR + idx) mod 2^ADDR_W. Go to CAPT.
- CAPT: load `rd_data` into the output register and update the argmax tracker. Go to SEND.
- SEND: `m_valid`=1, with `m_data`, `m_index`=idx and `m_last`=(idx==NUM_OUT-1) all stable.
  - Stay in SEND while `m_ready`=0.
  - On handshake with `m_last`=0: idx+1 and go to READ.
  - On handshake with `m_last`=1: go to DONE.
- DONE: `done`=1 and `argmax_valid` is set. Go to IDLE.
- Argmax rule:
  - signed comparison;
  - element 0 always loads;
  - a later element replaces the held one only if strictly greater, so ties keep the lowest index.
- `start` is ignored outside IDLE.
- `start` in the same cycle as DONE is also ignored, because the FSM is not yet in IDLE.
- Address arithmetic wraps modulo 2^ADDR_W.
- The block never writes the RAM and never drives its write port.

## Timing
- Reset values:
  - state IDLE, idx 0;
  - `busy`, `done`, `rd_en`, `m_valid`, `m_last`, `argmax_valid` = 0;
  - `rd_addr`, `m_data`, `m_index`, `argmax_index`, `argmax_value` = 0.
- Latency with `m_ready` held high:
  - `start` at cycle 0 gives READ at 1, CAPT at 2, first `m_valid` at 3;
  - each later element arrives every 3 cycles;
  - `done` comes 1 cycle after the last handshake.
- NUM_OUT=10 with `m_ready`=1: `done` at cycle 31.
- While `m_valid`=1 and `m_ready`=0, all `m_*` outputs are held unchanged and no RAM read is issued.
- `m_valid` never depends combinationally on `m_ready`.
- `reset` mid-operation returns the block to IDLE in the next cycle:
  - `m_valid` drops with no handshake;
  - the argmax outputs clear to 0 with `argmax_valid`=0.
- `reset` and `start` in the same cycle: reset wins.
- `argmax_valid` stays high from DONE until the next accepted `start` or `reset`.

## Structure
- Shared package `neural_pkg`:
  - state enum `reader_state_t`;
  - default `ADDR_W`/`DATA_W` constants, shared with the address generator and MAC core.
- Sub-module `argmax_tracker`:
  - signed compare plus registered value/index;
  - ports `clk`, `reset`, `clear`, `load`, `value`, `index`, `max_value`, `max_index`.
- The top-level holds the FSM, the index counter and the output register.

## Test plan
- Basic readout: RAM preloaded with 3,-5,7,0,12,-1,12,4,9,2 (BASE=0, NUM_OUT=10), `m_ready`=1, pulse `start`.
  - 10 beats in that order with indices 0..9, `m_last` on index 9.
  - `done` at cycle 31; argmax = index 4, value 12 (tie at index 7 loses).
- Backpressure: same data, `m_ready` low for 5 cycles while index 2 is presented.
  - `m_data`=7 and `m_index`=2 held stable;
  - no `rd_en` during the stall;
  - stream otherwise identical, `done` 5 cycles later.
- All negative, with NUM_OUT=1 and BASE=8'hFF holding -128: one beat with `m_last`=1 and `rd_addr`=8'hFF; argmax = index 0, value -128.
- Wrap-around: BASE=8'hFE, NUM_OUT=4. `rd_addr` sequence is FE, FF, 00, 01.
- Reset mid-stream: assert `reset` while in SEND on index 3.
  - Next cycle: IDLE with `m_valid`=0, `busy`=0, `argmax_valid`=0.
  - A new `start` replays from index 0.
- Start while busy: pulse `start` during READ of index 1 and again in the DONE cycle. Both are ignored, with one readout and one `done` pulse.

Source files
------------

// File: rtl/neural_pkg.sv
// Shared types and default widths for the neural accelerator datapath blocks.
package neural_pkg;

  localparam int NEURAL_ADDR_W = 8;
  localparam int NEURAL_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    DONE
  } reader_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum of a value stream together with the index where it was first seen.
module argmax_tracker #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] max_value,
  output logic [ADDR_W-1:0] max_index
);

  logic take;

  // Index 0 always seeds the tracker; later elements need a strictly greater value so ties keep the lowest index.
  assign take = load && ((index == '0) || ($signed(value) > $signed(max_value)));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      max_value <= '0;
      max_index <= '0;
    end else if (take) begin
      max_value <= value;
      max_index <= index;
    end
  end

endmodule

// File: rtl/neuron_result_reader.sv
// Streams the output-layer activations out of the neuron RAM and reports their argmax.
module neuron_result_reader
  import neural_pkg::*;
#(
  parameter int                ADDR_W    = NEURAL_ADDR_W,
  parameter int                DATA_W    = NEURAL_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_OUT   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] argmax_index,
  output logic [DATA_W-1:0] argmax_value,
  output logic              argmax_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  reader_state_t     state;
  logic [ADDR_W-1:0] idx;
  logic              trk_clear;
  logic              trk_load;

  assign trk_clear = (state == IDLE) && start;
  assign trk_load  = (state == CAPT);

  argmax_tracker #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .clear    (trk_clear),
    .load     (trk_load),
    .value    (rd_data),
    .index    (idx),
    .max_value(argmax_value),
    .max_index(argmax_index)
  );

  // Outputs are registered on state entry, so rd_en and rd_addr are already valid in READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      m_data       <= '0;
      m_index      <= '0;
      m_last       <= 1'b0;
      m_valid      <= 1'b0;
      argmax_valid <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx          <= '0;
            argmax_valid <= 1'b0;
            busy         <= 1'b1;
            rd_en        <= 1'b1;
            rd_addr      <= BASE_ADDR;
            state        <= READ;
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          m_data  <= rd_data;
          m_index <= idx;
          m_last  <= (idx == LAST_IDX);
          m_valid <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              done         <= 1'b1;
              argmax_valid <= 1'b1;
              state        <= DONE;
            end else begin
              idx     <= idx + ONE;
              rd_en   <= 1'b1;
              rd_addr <= BASE_ADDR + idx + ONE;
              state   <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_result_reader.sv
// Directed bench: three reader configurations share one RAM image; one is exercised at a time.
module tb_neuron_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic m_ready;
  int   sel;

  logic       start_v      [3];
  logic       busy_v       [3];
  logic       done_v       [3];
  logic       rd_en_v      [3];
  logic [7:0] rd_addr_v    [3];
  logic [7:0] rd_data_v    [3];
  logic [7:0] m_data_v     [3];
  logic [7:0] m_index_v    [3];
  logic       m_last_v     [3];
  logic       m_valid_v    [3];
  logic [7:0] am_index_v   [3];
  logic [7:0] am_value_v   [3];
  logic       am_valid_v   [3];

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  int beat_d[$];
  int beat_i[$];
  int beat_l[$];
  int addr_q[$];
  int done_cyc;
  int done_cnt;
  int busy_late;

  int exp_a[10] = '{3, -5, 7, 0, 12, -1, 12, 4, 9, 2};
  int exp_w[4]  = '{5, -128, 3, -5};
  int exp_wa[4] = '{254, 255, 0, 1};

  assign start_v[0] = start && (sel == 0);
  assign start_v[1] = start && (sel == 1);
  assign start_v[2] = start && (sel == 2);

  neuron_result_reader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00), .NUM_OUT(10)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]),
    .m_data(m_data_v[0]), .m_index(m_index_v[0]), .m_last(m_last_v[0]),
    .m_valid(m_valid_v[0]), .m_ready(m_ready),
    .argmax_index(am_index_v[0]), .argmax_value(am_value_v[0]), .argmax_valid(am_valid_v[0])
  );

  neuron_result_reader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFF), .NUM_OUT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]),
    .m_data(m_data_v[1]), .m_index(m_index_v[1]), .m_last(m_last_v[1]),
    .m_valid(m_valid_v[1]), .m_ready(m_ready),
    .argmax_index(am_index_v[1]), .argmax_value(am_value_v[1]), .argmax_valid(am_valid_v[1])
  );

  neuron_result_reader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFE), .NUM_OUT(4)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .rd_en(rd_en_v[2]), .rd_addr(rd_addr_v[2]), .rd_data(rd_data_v[2]),
    .m_data(m_data_v[2]), .m_index(m_index_v[2]), .m_last(m_last_v[2]),
    .m_valid(m_valid_v[2]), .m_ready(m_ready),
    .argmax_index(am_index_v[2]), .argmax_value(am_value_v[2]), .argmax_valid(am_valid_v[2])
  );

  // Synchronous-read RAM model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en_v[0]) rd_data_v[0] <= mem[rd_addr_v[0]];
    if (rd_en_v[1]) rd_data_v[1] <= mem[rd_addr_v[1]];
    if (rd_en_v[2]) rd_data_v[2] <= mem[rd_addr_v[2]];
  end

  logic       busy_s, done_s, rd_en_s, m_last_s, m_valid_s, am_valid_s;
  logic [7:0] rd_addr_s, m_data_s, m_index_s, am_index_s, am_value_s;

  always_comb begin
    busy_s     = busy_v[sel];
    done_s     = done_v[sel];
    rd_en_s    = rd_en_v[sel];
    rd_addr_s  = rd_addr_v[sel];
    m_data_s   = m_data_v[sel];
    m_index_s  = m_index_v[sel];
    m_last_s   = m_last_v[sel];
    m_valid_s  = m_valid_v[sel];
    am_index_s = am_index_v[sel];
    am_value_s = am_value_v[sel];
    am_valid_s = am_valid_v[sel];
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start at cycle 0, then walks cycles at the falling edge recording beats, reads and done.
  task automatic applyStimulus(input int s, input int stall_idx, input int stall_len,
                               input int hold_data, input int s1, input int s2, input int tail);
    int c;
    int stall;
    beat_d.delete();
    beat_i.delete();
    beat_l.delete();
    addr_q.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    busy_late = 0;
    stall     = 0;
    c         = 0;
    @(negedge clk);
    sel     = s;
    m_ready = 1'b1;
    start   = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      c++;
      start   = (c == s1) || (c == s2);
      m_ready = 1'b1;
      if (rd_en_s) addr_q.push_back(int'(rd_addr_s));
      if (m_valid_s) begin
        if (int'(m_index_s) == stall_idx && stall < stall_len) begin
          m_ready = 1'b0;
          stall++;
          checkOutput("stall_data", int'($signed(m_data_s)), hold_data);
          checkOutput("stall_index", int'(m_index_s), stall_idx);
          checkOutput("stall_rd_en", int'(rd_en_s), 0);
        end else begin
          beat_d.push_back(int'($signed(m_data_s)));
          beat_i.push_back(int'(m_index_s));
          beat_l.push_back(int'(m_last_s));
        end
      end
      if (done_s) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc && busy_s) busy_late++;
      if (done_cyc >= 0 && c >= done_cyc + tail) break;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    if (done_cyc < 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic checkStreamA(input string tag);
    checkOutput({tag, "_beats"}, beat_d.size(), 10);
    for (int i = 0; i < 10 && i < beat_d.size(); i++) begin
      checkOutput({tag, "_data"}, beat_d[i], exp_a[i]);
      checkOutput({tag, "_index"}, beat_i[i], i);
      checkOutput({tag, "_last"}, beat_l[i], (i == 9) ? 1 : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 10; i++) mem[i] = 8'(exp_a[i]);
    mem[8'hFE] = 8'd5;
    mem[8'hFF] = 8'h80;
    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b1;
    sel     = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy_s), 0);
    checkOutput("rst_done", int'(done_s), 0);
    checkOutput("rst_rd_en", int'(rd_en_s), 0);
    checkOutput("rst_m_valid", int'(m_valid_s), 0);
    checkOutput("rst_m_last", int'(m_last_s), 0);
    checkOutput("rst_am_valid", int'(am_valid_s), 0);
    checkOutput("rst_rd_addr", int'(rd_addr_s), 0);
    checkOutput("rst_m_data", int'(m_data_s), 0);
    checkOutput("rst_m_index", int'(m_index_s), 0);
    checkOutput("rst_am_index", int'(am_index_s), 0);
    checkOutput("rst_am_value", int'(am_value_s), 0);
    reset = 1'b0;

    // Basic readout
    $display("[TB] basic readout");
    applyStimulus(0, -1, 0, 0, -1, -1, 2);
    checkStreamA("basic");
    checkOutput("basic_done_cycle", done_cyc, 31);
    checkOutput("basic_done_count", done_cnt, 1);
    checkOutput("basic_reads", addr_q.size(), 10);
    for (int i = 0; i < 10 && i < addr_q.size(); i++) checkOutput("basic_rd_addr", addr_q[i], i);
    checkOutput("basic_am_index", int'(am_index_s), 4);
    checkOutput("basic_am_value", int'($signed(am_value_s)), 12);
    checkOutput("basic_am_valid", int'(am_valid_s), 1);

    // Backpressure on index 2
    $display("[TB] backpressure");
    applyStimulus(0, 2, 5, 7, -1, -1, 2);
    checkStreamA("bp");
    checkOutput("bp_done_cycle", done_cyc, 36);
    checkOutput("bp_reads", addr_q.size(), 10);
    checkOutput("bp_am_index", int'(am_index_s), 4);

    // Single all-negative element at the top of the address space
    $display("[TB] single element");
    applyStimulus(1, -1, 0, 0, -1, -1, 2);
    checkOutput("one_beats", beat_d.size(), 1);
    checkOutput("one_data", beat_d[0], -128);
    checkOutput("one_index", beat_i[0], 0);
    checkOutput("one_last", beat_l[0], 1);
    checkOutput("one_reads", addr_q.size(), 1);
    checkOutput("one_rd_addr", addr_q[0], 255);
    checkOutput("one_done_cycle", done_cyc, 4);
    checkOutput("one_am_index", int'(am_index_s), 0);
    checkOutput("one_am_value", int'($signed(am_value_s)), -128);
    checkOutput("one_am_valid", int'(am_valid_s), 1);

    // Address wrap-around
    $display("[TB] wrap-around");
    applyStimulus(2, -1, 0, 0, -1, -1, 2);
    checkOutput("wrap_reads", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) checkOutput("wrap_rd_addr", addr_q[i], exp_wa[i]);
    checkOutput("wrap_beats", beat_d.size(), 4);
    for (int i = 0; i < 4 && i < beat_d.size(); i++) begin
      checkOutput("wrap_data", beat_d[i], exp_w[i]);
      checkOutput("wrap_last", beat_l[i], (i == 3) ? 1 : 0);
    end
    checkOutput("wrap_done_cycle", done_cyc, 13);
    checkOutput("wrap_am_index", int'(am_index_s), 0);
    checkOutput("wrap_am_value", int'($signed(am_value_s)), 5);

    // Reset while index 3 is being presented
    $display("[TB] reset mid-stream");
    begin
      int found;
      found = 0;
      @(negedge clk);
      sel   = 0;
      start = 1'b1;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (m_valid_s && m_index_s == 8'd3) begin
          found = 1;
          break;
        end
      end
      checkOutput("mid_reach_idx3", found, 1);
      checkOutput("mid_am_value_before", int'($signed(am_value_s)), 7);
      m_ready = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      checkOutput("mid_m_valid", int'(m_valid_s), 0);
      checkOutput("mid_busy", int'(busy_s), 0);
      checkOutput("mid_am_valid", int'(am_valid_s), 0);
      checkOutput("mid_am_value", int'(am_value_s), 0);
      checkOutput("mid_am_index", int'(am_index_s), 0);
      reset   = 1'b0;
      m_ready = 1'b1;
    end
    applyStimulus(0, -1, 0, 0, -1, -1, 2);
    checkStreamA("replay");
    checkOutput("replay_done_cycle", done_cyc, 31);

    // Start pulses during READ of index 1 and in the DONE cycle
    $display("[TB] start while busy");
    applyStimulus(0, -1, 0, 0, 4, 31, 6);
    checkStreamA("sbusy");
    checkOutput("sbusy_done_cycle", done_cyc, 31);
    checkOutput("sbusy_done_count", done_cnt, 1);
    checkOutput("sbusy_reads", addr_q.size(), 10);
    checkOutput("sbusy_busy_after", busy_late, 0);
    checkOutput("sbusy_am_valid", int'(am_valid_s), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
